// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces the scanner key code into press / repeat / release
// events and queues them in a small first-word-fall-through FIFO for the host.
// Optional feature macro: KEY_REPEAT_EN builds the auto-repeat logic; without
// it a held key produces only its press event and its release event.
module key_event_ctrl #(
    parameter int CLK_PER_MS      = 1000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk_1mhz,
    input  logic                          reset,
    input  logic [7:0]                    key_code,
    input  logic                          rd_en,
    input  logic                          ovf_clr,
    output logic [8:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          key_irq,
    output logic                          overflow
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PS_TC    = PW'(CLK_PER_MS - 1);
    localparam logic [7:0]    DB_TGT   = 8'(DEBOUNCE_MS);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef KEY_REPEAT_EN
    localparam logic [11:0]   DELAY_TGT = 12'(REPEAT_DELAY_MS);
    localparam logic [11:0]   RATE_TGT  = 12'(REPEAT_RATE_MS);
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      kc_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      cand_q, cand_d;
    logic [7:0]      db_cnt_q, db_cnt_d;
`ifdef KEY_REPEAT_EN
    logic [11:0]     rep_cnt_q, rep_cnt_d;
    logic            first_q, first_d;
`endif
    logic            tick_s;
    logic            push_s;
    logic [8:0]      push_data_s;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            key_irq_q, key_irq_d;
    logic            pop_s, full_s, wr_s, drop_s;

    assign tick_s = (presc_q == PS_TC);

    // Prescaler next value: count up to the terminal count, then wrap to zero.
    always_comb begin
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Debounce / repeat FSM: next state, counters and event push request.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        db_cnt_d    = db_cnt_q;
        push_s      = 1'b0;
        push_data_s = 9'h000;
`ifdef KEY_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        first_d     = first_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (kc_q != 8'hFF) begin
                    cand_d   = kc_q;
                    db_cnt_d = 8'h00;
                    state_d  = S_DEBOUNCE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_DEBOUNCE: begin
                if (kc_q != cand_q) begin
                    if (kc_q == 8'hFF) begin
                        state_d  = S_IDLE;
                    end else begin
                        cand_d   = kc_q;
                        db_cnt_d = 8'h00;
                    end
                end else if (db_cnt_q == DB_TGT) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b0, cand_q};
                    state_d     = S_HELD;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d   = 12'h000;
                    first_d     = 1'b0;
`endif
                end else if (tick_s) begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end else begin
                    db_cnt_d = db_cnt_q;
                end
            end
            S_HELD: begin
                if (kc_q != cand_q) begin
                    db_cnt_d = 8'h00;
                    state_d  = S_RELEASE;
                end else begin
`ifdef KEY_REPEAT_EN
                    // The first repeat waits the long delay, later ones the rate.
                    if (rep_cnt_q == (first_q ? RATE_TGT : DELAY_TGT)) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, cand_q};
                        rep_cnt_d   = 12'h000;
                        first_d     = 1'b1;
                    end else if (tick_s) begin
                        rep_cnt_d = rep_cnt_q + 12'd1;
                    end else begin
                        rep_cnt_d = rep_cnt_q;
                    end
`else
                    state_d = S_HELD;
`endif
                end
            end
            S_RELEASE: begin
                // A bounce back to the held key resumes repeat timing where it was.
                if (kc_q == cand_q) begin
                    state_d = S_HELD;
                end else if (db_cnt_q == DB_TGT) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b1, cand_q};
                    state_d     = S_IDLE;
                end else if (tick_s) begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end else begin
                    db_cnt_d = db_cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a push into a full FIFO is kept only when a pop frees a slot.
    always_comb begin
        pop_s    = rd_en && (cnt_q != {CW{1'b0}});
        full_s   = (cnt_q == FULL_CNT);
        wr_s     = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        wr_ptr_d = wr_s  ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        key_irq_d = (cnt_d != {CW{1'b0}});
    end

    // State, counters, input register and FIFO bookkeeping registers.
    always_ff @(posedge clk_1mhz or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kc_q       <= 8'hFF;
            presc_q    <= {PW{1'b0}};
            cand_q     <= 8'hFF;
            db_cnt_q   <= 8'h00;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= 12'h000;
            first_q    <= 1'b0;
`endif
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            overflow_q <= 1'b0;
            key_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kc_q       <= key_code;
            presc_q    <= presc_d;
            cand_q     <= cand_d;
            db_cnt_q   <= db_cnt_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            first_q    <= first_d;
`endif
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            key_irq_q  <= key_irq_d;
        end
    end

    // Event storage: written at the tail on every accepted push.
    always_ff @(posedge clk_1mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else if (wr_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign rd_data  = (cnt_q == {CW{1'b0}}) ? 9'h1FF : mem_q[rd_ptr_q];
    assign fifo_cnt = cnt_q;
    assign key_irq  = key_irq_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios plus random key
// activity, all compared every cycle against an event-level reference model.
module tb_key_event_ctrl;

    localparam int CPM = 10;
    localparam int DB  = 3;
    localparam int RD  = 5;
    localparam int RR  = 2;
    localparam int DEP = 4;

    logic       clk_1mhz = 1'b0;
    logic       reset;
    logic [7:0] key_code;
    logic       rd_en;
    logic       ovf_clr;
    logic [8:0] rd_data;
    logic [2:0] fifo_cnt;
    logic       key_irq;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    key_event_ctrl #(
        .CLK_PER_MS(CPM), .DEBOUNCE_MS(DB), .REPEAT_DELAY_MS(RD),
        .REPEAT_RATE_MS(RR), .FIFO_DEPTH(DEP)
    ) dut (
        .clk_1mhz(clk_1mhz), .reset(reset), .key_code(key_code),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data),
        .fifo_cnt(fifo_cnt), .key_irq(key_irq), .overflow(overflow)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    // Key life cycle: not down (optionally tracking a candidate), down, and
    // down-but-releasing. Stable time counted in ticks, FIFO is a queue.
    logic [8:0] m_q[$];
    logic [7:0] m_kc;
    logic [7:0] m_cand;
    bit         m_track;
    bit         m_down;
    bit         m_rel;
    bit         m_ovf;
    int         m_presc;
    int         m_stable;
    int         m_held;
    int         m_nrep;

    always @(posedge clk_1mhz or posedge reset) begin : model
        bit         tick;
        bit         push;
        bit         dropped;
        logic [8:0] pd;
        if (reset) begin
            m_q.delete();
            m_kc = 8'hFF; m_cand = 8'hFF;
            m_track = 1'b0; m_down = 1'b0; m_rel = 1'b0; m_ovf = 1'b0;
            m_presc = 0; m_stable = 0; m_held = 0; m_nrep = 0;
        end else begin
            tick = (m_presc == CPM - 1);
            push = 1'b0; dropped = 1'b0; pd = 9'h000;
            if (!m_down) begin
                if (!m_track) begin
                    if (m_kc != 8'hFF) begin
                        m_track = 1'b1; m_cand = m_kc; m_stable = 0;
                    end
                end else if (m_kc != m_cand) begin
                    if (m_kc == 8'hFF) m_track = 1'b0;
                    else begin m_cand = m_kc; m_stable = 0; end
                end else if (m_stable == DB) begin
                    push = 1'b1; pd = {1'b0, m_cand};
                    m_down = 1'b1; m_track = 1'b0; m_held = 0; m_nrep = 0;
                end else if (tick) begin
                    m_stable++;
                end
            end else if (m_kc == m_cand) begin
                if (m_rel) begin
                    m_rel = 1'b0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (m_held == ((m_nrep == 0) ? RD : RR)) begin
                        push = 1'b1; pd = {1'b0, m_cand}; m_held = 0; m_nrep++;
                    end else if (tick) begin
                        m_held++;
                    end
`endif
                end
            end else begin
                if (!m_rel) begin
                    m_rel = 1'b1; m_stable = 0;
                end else if (m_stable == DB) begin
                    push = 1'b1; pd = {1'b1, m_cand};
                    m_down = 1'b0; m_rel = 1'b0;
                end else if (tick) begin
                    m_stable++;
                end
            end
            if (rd_en && m_q.size() != 0) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEP) m_q.push_back(pd);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_presc = tick ? 0 : m_presc + 1;
            m_kc = key_code;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_1mhz) begin
        if (!reset) begin
            chk("rd_data",  32'(rd_data),  32'((m_q.size() != 0) ? m_q[0] : 9'h1FF));
            chk("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
            chk("key_irq",  32'(key_irq),  32'(m_q.size() != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_1mhz);
    endtask

    task automatic pop_one(output logic [8:0] v);
        v = rd_data;
        rd_en = 1'b1;
        @(negedge clk_1mhz);
        rd_en = 1'b0;
    endtask

    task automatic wait_grow(input string nm, input int budget);
        int start = m_q.size();
        int n = 0;
        while (m_q.size() == start && n < budget) begin
            @(negedge clk_1mhz);
            n++;
        end
        chk(nm, 32'(n < budget), 32'd1);
    endtask

    task automatic press_release(input logic [7:0] code);
        key_code = code;
        wait_grow("press_timeout", 80);
        key_code = 8'hFF;
        wait_grow("release_timeout", 80);
        cyc(2);
    endtask

    task automatic drain();
        logic [8:0] v;
        int n = m_q.size();
        for (int i = 0; i < n; i++) pop_one(v);
    endtask

    initial begin
        logic [8:0] v;
        logic [8:0] first_v;
        logic [8:0] last_v;
        int n;
        bit irq_seen;

        reset = 1'b1; key_code = 8'hFF; rd_en = 1'b0; ovf_clr = 1'b0;
        cyc(3);
        chk("rst_rd_data",  32'(rd_data),  32'h1FF);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_key_irq",  32'(key_irq),  32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Scenario 1: press and release of 7E.
        key_code = 8'h7E;
        n = 0;
        while (fifo_cnt == 3'd0 && n < 60) begin
            @(negedge clk_1mhz);
            n++;
        end
        chk_rng("press_latency", n, 24, 33);
        cyc(100 - n);
        key_code = 8'hFF;
        cyc(60);
`ifdef KEY_REPEAT_EN
        chk_rng("s1_count", int'(fifo_cnt), 3, 4);
`else
        chk("s1_count", 32'(fifo_cnt), 32'd2);
`endif
        n = m_q.size();
        first_v = 9'h000; last_v = 9'h000;
        for (int i = 0; i < n; i++) begin
            pop_one(v);
            if (i == 0) first_v = v;
            last_v = v;
        end
        chk("s1_first", 32'(first_v), 32'h07E);
        chk("s1_last",  32'(last_v),  32'h17E);
        chk("s1_empty_data", 32'(rd_data), 32'h1FF);

        // Scenario 2: bouncing key never qualifies.
        irq_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            key_code = (i % 2 == 0) ? 8'h7E : 8'hFF;
            repeat (15) begin
                @(negedge clk_1mhz);
                irq_seen = irq_seen | key_irq;
            end
        end
        key_code = 8'hFF;
        cyc(40);
        chk("toggle_irq", 32'(irq_seen), 32'd0);
        chk("toggle_cnt", 32'(fifo_cnt), 32'd0);

        // Scenario 3/4: long hold without reads.
        key_code = 8'h7E;
        cyc(170);
`ifdef KEY_REPEAT_EN
        chk("hold_cnt", 32'(fifo_cnt), 32'd4);
        chk("hold_ovf", 32'(overflow), 32'd1);
`else
        chk("hold_cnt",  32'(fifo_cnt), 32'd1);
        chk("hold_ovf",  32'(overflow), 32'd0);
        chk("hold_head", 32'(rd_data),  32'h07E);
`endif
        key_code = 8'hFF;
        cyc(1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        drain();
        cyc(60);
        chk("hold_release", 32'(rd_data), 32'h17E);
        drain();

        // Scenario 5: push and pop together while full.
        press_release(8'h11);
        press_release(8'h22);
        chk("fill_cnt", 32'(fifo_cnt), 32'd4);
        key_code = 8'h33;
        n = 0;
        while (!(m_track && m_stable == DB && m_cand == 8'h33) && n < 80) begin
            @(negedge clk_1mhz);
            n++;
        end
        chk("full_wait", 32'(n < 80), 32'd1);
        rd_en = 1'b1;
        @(negedge clk_1mhz);
        rd_en = 1'b0;
        chk("full_pp_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        pop_one(v); chk("full_e0", 32'(v), 32'h111);
        pop_one(v); chk("full_e1", 32'(v), 32'h022);
        pop_one(v); chk("full_e2", 32'(v), 32'h122);
        pop_one(v); chk("full_e3", 32'(v), 32'h033);
        key_code = 8'hFF;
        wait_grow("full_rel_timeout", 80);
        drain();

        // Scenario 6: reset while held with events queued.
        press_release(8'h55);
        key_code = 8'h66;
        wait_grow("rst_press_timeout", 80);
        pop_one(v);
        cyc(3);
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_cnt",  32'(fifo_cnt), 32'd0);
        chk("midrst_irq",  32'(key_irq),  32'd0);
        chk("midrst_data", 32'(rd_data),  32'h1FF);
        key_code = 8'hFF;
        cyc(2);
        reset = 1'b0;
        cyc(60);
        chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("post_rst_irq", 32'(key_irq),  32'd0);

        // Random key activity with sparse reads and occasional clears.
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 4))
                0:       key_code = 8'h7E;
                1:       key_code = 8'h3D;
                2:       key_code = 8'hBB;
                default: key_code = 8'hFF;
            endcase
            repeat ($urandom_range(1, 45)) begin
                rd_en   = ($urandom_range(0, 3) == 0);
                ovf_clr = ($urandom_range(0, 40) == 0);
                @(negedge clk_1mhz);
            end
        end
        rd_en = 1'b0; ovf_clr = 1'b0; key_code = 8'hFF;
        cyc(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
